quant: RTL and testbench
========================

Name: quant

Overview:
- Quantizer stage directly downstream of the 2-D DCT/zigzag block.
- Consumes two zigzag-ordered coefficients per cycle (32 beats per 8x8 block) and multiplies each by a programmable reciprocal of the quantization step. The AAN scale factor and the 2-D normalization are pre-folded into that reciprocal.
- Rounds and saturates each result and emits two quantized coefficients per cycle to the entropy coder.
- Holds two reciprocal tables (luma/chroma) written by the host between frames.

Parameters:
- DW, 15, signed input coefficient width (DCT output width).
- RW, 16, unsigned reciprocal width.
- SHIFT, 16, right shift applied after multiply (reciprocal fixed-point fraction bits).
- OW, 11, signed output coefficient width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- d  in  DW x2 (d[1:0])  signed coefficients; d[0] is zigzag index 2*d_cnt, d[1] is 2*d_cnt+1.
- d_valid  in  1  input beat valid.
- d_hold  out  1  stall request to upstream.
- d_cnt  in  5  beat index within block, 0..31.
- d_qt_sel  in  1  table select for this beat (0 = luma, 1 = chroma).
- q  out  OW x2 (q[1:0])  quantized coefficients, same ordering as d.
- q_valid  out  1  output beat valid.
- q_hold  in  1  downstream stall.
- q_cnt  out  5  d_cnt carried with the beat.
- qt_wr_en  in  1  table write strobe.
- qt_wr_addr  in  7  bit6 = table select, bits5:0 = zigzag index.
- qt_wr_data  in  RW  reciprocal value.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset resetn is asynchronous, active-low.
- Handshake:
  - A beat transfers on d_valid && !d_hold. An output beat is consumed on q_valid && !q_hold.
  - The payload (q, q_cnt) must stay stable while q_valid && q_hold.
- Stall: stall = q_valid && q_hold; d_hold = stall (combinational).
  - When stall is asserted, every pipeline register, including the table read address/data register, holds its value.
  - No beat is dropped or duplicated under any hold pattern.
- Pipeline: 3 stages; latency 3 cycles from input transfer to q_valid when there is no stall. Full throughput is 1 beat per cycle.
  - S1: registered table read. Two read ports at addresses {d_qt_sel, d_cnt, 1'b0} and {d_qt_sel, d_cnt, 1'b1}. Coefficients, d_cnt and valid are registered alongside.
  - S2: signed multiply p = d * $signed({1'b0, recip}), full DW+RW+1 bits, registered.
  - S3: round half away from zero: m = |p|, r = (m + 2^(SHIFT-1)) >> SHIFT, sign restored. Saturate to [-(2^(OW-1)-1), 2^(OW-1)-1], i.e. ±1023, so the result is symmetric. Registered into q.
- Valid bubbles propagate unchanged. A stage whose valid is 0 still advances when there is no stall.
- Table:
  - 128 x RW storage; contents are not reset.
  - Writes complete in 1 cycle and take effect regardless of the data path.
  - If a write and a read hit the same address in the same cycle, the read returns the old value.
  - Host writes only between frames; mid-block writes are legal but the beats affected are unspecified.
- Reset (asynchronous, any time, including mid-block): q_valid = 0, q = 0, q_cnt = 0, all stage valids = 0. d_hold is 0 after reset.
  - Partial blocks in flight are discarded. The first beat after reset is treated purely by its own d_cnt; there is no internal block counter.
- d_cnt is not checked. Out-of-order indices simply select the corresponding table entries.
- Zero reciprocal gives q = 0.

Decomposition:
- Shared jenc package holds: the OW/RW/SHIFT defaults, a rounding/saturation function (round_sat) usable by other stages, and the qt address field layout (table-select bit position).
- One sub-module: quant_table_ram. It is a 128 x RW RAM with 1 write port and 2 registered read ports, has a read-enable used for stall holding, and maps to distributed/EBR RAM.
- The multiply and round logic is instantiated twice inline, one copy per lane.

Test Plan:
- Write luma entries 0..63 = 0x1000 (÷16). Send beat d_cnt=0 with d = {100, -24}. Required: q = {6, -2} after 3 cycles, q_cnt = 0.
- Rounding ties: recip 0x1000 with d = {8, -8}. Required: q = {1, -1}. With d = {7, -7}, required: q = {0, 0}.
- Saturation: chroma entry 5 = 0xFFFF, d_qt_sel = 1, d_cnt = 2 (index 5 is lane 1), d = {0, 16383}. Required: q = {0, 1023}. Same with d = -16384: required lane 1 = -1023.
- Backpressure: stream 32 beats with d[0] = 2*cnt, d[1] = 2*cnt+1, recip 0x10000 not representable so use 0xFFFF. Assert q_hold for random cycles, including 5 consecutive cycles. Required: 32 output beats in order with q_cnt 0..31; q stable while held; d_hold mirrors q_valid && q_hold.
- Table select: distinct luma (0x2000) and chroma (0x0800) values, alternating blocks by d_qt_sel with d = 64. Required: 8 for luma beats and 2 for chroma beats.
- Reset mid-block: assert resetn = 0 at beat 10 with q_hold = 1. Required: q_valid = 0 and q = 0 immediately (asynchronous), d_hold = 0, table contents preserved. The next block quantizes correctly.

Source files
------------

// File: rtl/jenc_pkg.sv
// Shared definitions for the JPEG encoder datapath: default widths, quant-table
// address layout and the rounding/saturation helper used by the quantizer.
package jenc_pkg;

  localparam int DW_DEF    = 15;
  localparam int RW_DEF    = 16;
  localparam int SHIFT_DEF = 16;
  localparam int OW_DEF    = 11;

  localparam int QT_AW      = 7;
  localparam int QT_SEL_BIT = 6;
  localparam int RS_W       = 64;

  // Quant-table address: table select on top, zigzag index below.
  typedef struct packed {
    logic       sel;
    logic [5:0] idx;
  } qt_addr_t;

  // Round half away from zero after a right shift by 'shift', then clamp the
  // magnitude to 2^(ow-1)-1 so the output range is symmetric.
  function automatic logic signed [31:0] round_sat(
    input logic signed [RS_W-1:0] p,
    input int                     shift,
    input int                     ow
  );
    logic [RS_W-1:0] m;
    logic [RS_W-1:0] r;
    logic [RS_W-1:0] lim;
    m   = p[RS_W-1] ? -p : p;
    m   = m + (RS_W'(1) << (shift - 1));
    r   = m >> shift;
    lim = (RS_W'(1) << (ow - 1)) - RS_W'(1);
    if (r > lim) r = lim;
    if (p[RS_W-1]) r = -r;
    return r[31:0];
  endfunction

endpackage

// File: rtl/quant_table_ram.sv
// 128 x RW reciprocal storage: one write port, two registered read ports.
// Read enable freezes the read registers while the pipeline is stalled.
module quant_table_ram #(
  parameter int AW = 7,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [RW-1:0] i_wd,
  input  logic          i_re,
  input  logic [AW-1:0] i_ra0,
  input  logic [AW-1:0] i_ra1,
  output logic [RW-1:0] o_rd0,
  output logic [RW-1:0] o_rd1
);

  logic [RW-1:0] r_mem [2**AW];
  logic [RW-1:0] r_rd0;
  logic [RW-1:0] r_rd1;

  // Reads sample the array before this cycle's write lands (read-old).
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
    if (i_re) begin
      r_rd0 <= r_mem[i_ra0];
      r_rd1 <= r_mem[i_ra1];
    end
  end

  assign o_rd0 = r_rd0;
  assign o_rd1 = r_rd1;

endmodule

// File: rtl/quant.sv
// Two-lane quantizer: table read, signed multiply by reciprocal, round and
// saturate. Three stages, one beat per cycle, global stall from downstream.
module quant
  import jenc_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RW    = RW_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OW    = OW_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0][DW-1:0]  d,
  input  logic                d_valid,
  output logic                d_hold,
  input  logic [4:0]          d_cnt,
  input  logic                d_qt_sel,
  output logic [1:0][OW-1:0]  q,
  output logic                q_valid,
  input  logic                q_hold,
  output logic [4:0]          q_cnt,
  input  logic                qt_wr_en,
  input  logic [QT_AW-1:0]    qt_wr_addr,
  input  logic [RW-1:0]       qt_wr_data
);

  localparam int PW = DW + RW + 1;

  logic                 w_stall;
  qt_addr_t             w_ra0;
  qt_addr_t             w_ra1;
  logic [RW-1:0]        w_rd [2];
  logic signed [PW-1:0] w_prod [2];
  logic [OW-1:0]        w_q [2];

  logic                 r_v1;
  logic [4:0]           r_cnt1;
  logic [DW-1:0]        r_d1 [2];
  logic                 r_v2;
  logic [4:0]           r_cnt2;
  logic signed [PW-1:0] r_p [2];

  assign w_stall = q_valid && q_hold;
  assign d_hold  = w_stall;

  assign w_ra0 = '{sel: d_qt_sel, idx: {d_cnt, 1'b0}};
  assign w_ra1 = '{sel: d_qt_sel, idx: {d_cnt, 1'b1}};

  quant_table_ram #(
    .AW (QT_AW),
    .RW (RW)
  ) u_table (
    .clk   (clk),
    .i_we  (qt_wr_en),
    .i_wa  (qt_wr_addr),
    .i_wd  (qt_wr_data),
    .i_re  (!w_stall),
    .i_ra0 (w_ra0),
    .i_ra1 (w_ra1),
    .o_rd0 (w_rd[0]),
    .o_rd1 (w_rd[1])
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [PW-1:0] w_dx;
      logic signed [PW-1:0] w_rx;
      // Reciprocal is unsigned, so zero-extend before the signed multiply.
      assign w_dx       = {{(PW-DW){r_d1[gi][DW-1]}}, r_d1[gi]};
      assign w_rx       = {{(PW-RW){1'b0}}, w_rd[gi]};
      assign w_prod[gi] = w_dx * w_rx;
      assign w_q[gi]    = OW'(round_sat({{(RS_W-PW){r_p[gi][PW-1]}}, r_p[gi]}, SHIFT, OW));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v1    <= 1'b0;
      r_cnt1  <= '0;
      r_d1    <= '{default: '0};
      r_v2    <= 1'b0;
      r_cnt2  <= '0;
      r_p     <= '{default: '0};
      q_valid <= 1'b0;
      q_cnt   <= '0;
      q       <= '0;
    end else if (!w_stall) begin
      r_v1    <= d_valid;
      r_cnt1  <= d_cnt;
      r_d1[0] <= d[0];
      r_d1[1] <= d[1];
      r_v2    <= r_v1;
      r_cnt2  <= r_cnt1;
      r_p[0]  <= w_prod[0];
      r_p[1]  <= w_prod[1];
      q_valid <= r_v2;
      q_cnt   <= r_cnt2;
      q[0]    <= w_q[0];
      q[1]    <= w_q[1];
    end
  end

endmodule

// File: tb/tb_quant.sv
// Randomized bench for quant: arithmetic reference model plus an in-order
// scoreboard of expected output beats.
module tb_quant;

  localparam int DW = 15;
  localparam int RW = 16;
  localparam int OW = 11;

  logic                clk = 1'b0;
  logic                resetn;
  logic [1:0][DW-1:0]  d;
  logic                d_valid;
  logic                d_hold;
  logic [4:0]          d_cnt;
  logic                d_qt_sel;
  logic [1:0][OW-1:0]  q;
  logic                q_valid;
  logic                q_hold;
  logic [4:0]          q_cnt;
  logic                qt_wr_en;
  logic [6:0]          qt_wr_addr;
  logic [RW-1:0]       qt_wr_data;

  quant dut (
    .clk        (clk),
    .resetn     (resetn),
    .d          (d),
    .d_valid    (d_valid),
    .d_hold     (d_hold),
    .d_cnt      (d_cnt),
    .d_qt_sel   (d_qt_sel),
    .q          (q),
    .q_valid    (q_valid),
    .q_hold     (q_hold),
    .q_cnt      (q_cnt),
    .qt_wr_en   (qt_wr_en),
    .qt_wr_addr (qt_wr_addr),
    .qt_wr_data (qt_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d0;
    int d1;
    int cnt;
    bit sel;
  } beat_t;

  typedef struct {
    int q0;
    int q1;
    int cnt;
  } exp_t;

  int    total = 0;
  int    bad   = 0;
  int    tbl [128];
  beat_t pend [$];
  exp_t  sb [$];
  int    step_no = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Quantization as plain integer arithmetic: |d*recip|/65536 rounded, clamped.
  function automatic int qmodel(input int dv, input int rc);
    longint p, m, r;
    p = longint'(dv) * longint'(rc);
    m = (p < 0) ? -p : p;
    r = (m + 32768) / 65536;
    if (r > 1023) r = 1023;
    return (p < 0) ? -int'(r) : int'(r);
  endfunction

  task automatic wr(input int a, input int v);
    @(negedge clk);
    qt_wr_en   = 1'b1;
    qt_wr_addr = 7'(a);
    qt_wr_data = 16'(v);
    d_valid    = 1'b0;
    q_hold     = 1'b0;
    tbl[a]     = v & 16'hFFFF;
  endtask

  task automatic add(input int d0, input int d1, input int cnt, input bit sel);
    beat_t b;
    b.d0 = d0; b.d1 = d1; b.cnt = cnt; b.sel = sel;
    pend.push_back(b);
  endtask

  // One clock: drive, then observe just after the falling edge.
  task automatic step(input bit hold, input bit offer);
    exp_t e;
    int   base;
    @(negedge clk);
    step_no++;
    qt_wr_en = 1'b0;
    q_hold   = hold;
    if (offer && pend.size() > 0) begin
      d_valid  = 1'b1;
      d[0]     = DW'(pend[0].d0);
      d[1]     = DW'(pend[0].d1);
      d_cnt    = 5'(pend[0].cnt);
      d_qt_sel = pend[0].sel;
    end else begin
      d_valid  = 1'b0;
      d[0]     = DW'($urandom);
      d[1]     = DW'($urandom);
      d_cnt    = 5'($urandom);
      d_qt_sel = 1'($urandom);
    end
    #1;
    check("d_hold", d_hold, q_valid && hold);
    if (q_valid) begin
      if (sb.size() == 0) begin
        check("q_valid_spurious", q_valid, 0);
      end else begin
        check("q0", $signed(q[0]), sb[0].q0);
        check("q1", $signed(q[1]), sb[0].q1);
        check("q_cnt", q_cnt, sb[0].cnt);
        if (!hold) void'(sb.pop_front());
      end
    end
    if (d_valid && !d_hold) begin
      base = (pend[0].sel ? 64 : 0) + 2 * pend[0].cnt;
      e.q0  = qmodel(pend[0].d0, tbl[base]);
      e.q1  = qmodel(pend[0].d1, tbl[base + 1]);
      e.cnt = pend[0].cnt;
      sb.push_back(e);
      void'(pend.pop_front());
    end
  endtask

  task automatic run_all(input int hold_pct, input int gap_pct, input bit burst);
    int  n = 0;
    bit  h;
    while ((pend.size() > 0 || sb.size() > 0) && n < 3000) begin
      h = ($urandom_range(0, 99) < hold_pct);
      if (burst && n >= 8 && n < 13) h = 1'b1;
      step(h, $urandom_range(0, 99) >= gap_pct);
      n++;
    end
    check("drain_timeout", pend.size() + sb.size(), 0);
  endtask

  initial begin
    resetn     = 1'b0;
    d          = '0;
    d_valid    = 1'b0;
    d_cnt      = '0;
    d_qt_sel   = 1'b0;
    q_hold     = 1'b0;
    qt_wr_en   = 1'b0;
    qt_wr_addr = '0;
    qt_wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_q_valid", q_valid, 0);
    check("rst_q0", q[0], 0);
    check("rst_q_cnt", q_cnt, 0);
    check("rst_d_hold", d_hold, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int a = 0; a < 128; a++) wr(a, int'($urandom_range(0, 65535)));

    // Basic divide-by-16 with explicit latency.
    for (int a = 0; a < 64; a++) wr(a, 'h1000);
    add(100, -24, 0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("lat_c1", q_valid, 0);
    step(1'b0, 1'b0);
    check("lat_c2", q_valid, 0);
    step(1'b0, 1'b0);
    check("lat_c3", q_valid, 1);
    check("tp1_q0", $signed(q[0]), 6);
    check("tp1_q1", $signed(q[1]), -2);
    check("tp1_cnt", q_cnt, 0);

    // Rounding ties.
    add(8, -8, 1, 1'b0);
    add(7, -7, 3, 1'b0);
    run_all(0, 0, 1'b0);

    // Saturation on chroma entry 5.
    wr(69, 'hFFFF);
    add(0, 16383, 2, 1'b1);
    add(0, -16384, 2, 1'b1);
    run_all(0, 0, 1'b0);

    // Backpressure with a 5-cycle hold run.
    for (int a = 0; a < 64; a++) wr(a, 'hFFFF);
    for (int c = 0; c < 32; c++) add(2 * c, 2 * c + 1, c, 1'b0);
    run_all(35, 0, 1'b1);

    // Table select: alternating luma / chroma blocks.
    for (int a = 0; a < 64; a++) wr(a, 'h2000);
    for (int a = 64; a < 128; a++) wr(a, 'h0800);
    for (int blk = 0; blk < 4; blk++)
      for (int c = 0; c < 32; c++) add(64, 64, c, 1'(blk));
    run_all(10, 10, 1'b0);

    // Random traffic over random tables.
    for (int a = 0; a < 128; a++) wr(a, int'($urandom_range(0, 65535)));
    wr(7, 0);
    for (int i = 0; i < 300; i++)
      add(int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384,
          int'($urandom_range(0, 31)), 1'($urandom));
    run_all(30, 25, 1'b0);

    // Asynchronous reset mid-block while downstream holds.
    for (int c = 0; c < 32; c++)
      add(int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384, c, 1'b0);
    for (int n = 0; n < 50 && pend.size() > 22; n++) step(1'b0, 1'b1);
    @(negedge clk);
    q_hold  = 1'b1;
    d_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_q_valid", q_valid, 0);
    check("arst_q0", q[0], 0);
    check("arst_q1", q[1], 0);
    check("arst_q_cnt", q_cnt, 0);
    check("arst_d_hold", d_hold, 0);
    pend.delete();
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 32; c++)
      add(int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384, c, 1'($urandom));
    run_all(20, 10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
